// File: rtl/stopwatch_ctrl_if.sv
// Signal bundle between stopwatch_ctrl, the front-panel inputs and the BCD counter chain.
// Lap signals exist only when STOPWATCH_CTRL_LAP_EN is defined.
interface stopwatch_ctrl_if #(
    parameter int LOAD_W = 15
);
    logic              btn_start_i;
    logic              btn_clear_i;
    logic              dir_i;
    logic [LOAD_W-1:0] load_value_i;
    logic              count_end_i;
    logic              tick_en_o;
    logic              clear_o;
    logic              load_o;
    logic [LOAD_W-1:0] load_value_o;
    logic              dir_o;
    logic [1:0]        state_o;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic              btn_lap_i;
    logic              lap_freeze_o;

    modport master (
        input  btn_start_i, btn_clear_i, btn_lap_i, dir_i, load_value_i, count_end_i,
        output tick_en_o, clear_o, load_o, load_value_o, dir_o, state_o, lap_freeze_o
    );
    modport slave (
        output btn_start_i, btn_clear_i, btn_lap_i, dir_i, load_value_i, count_end_i,
        input  tick_en_o, clear_o, load_o, load_value_o, dir_o, state_o, lap_freeze_o
    );
`else
    modport master (
        input  btn_start_i, btn_clear_i, dir_i, load_value_i, count_end_i,
        output tick_en_o, clear_o, load_o, load_value_o, dir_o, state_o
    );
    modport slave (
        output btn_start_i, btn_clear_i, dir_i, load_value_i, count_end_i,
        input  tick_en_o, clear_o, load_o, load_value_o, dir_o, state_o
    );
`endif
endinterface

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning, IDLE/RUN/PAUSE/DONE sequencing and count-enable tick
// for the BCD stopwatch counter chain. Optional lap freeze output: define STOPWATCH_CTRL_LAP_EN.
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 262_144,
    parameter int LOAD_W          = 15
) (
    input  logic             clk,
    input  logic             reset,
    stopwatch_ctrl_if.master bus
);
    localparam int DIV  = CLK_HZ / TICK_HZ;
    localparam int PS_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif
    localparam int BTN_START = 0;
    localparam int BTN_CLEAR = 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    logic [NB-1:0]           btn_raw, sync_a, sync_b, deb, deb_q, press;
    logic [NB-1:0][DB_W-1:0] db_cnt;
    logic                    dir_a, dir_b;
    state_t                  state, state_nxt;
    logic [PS_W-1:0]         presc, presc_nxt;
    logic                    tick_due, tick_en;
    logic                    clear_r, load_r, dir_r;
    logic [LOAD_W-1:0]       load_value_r;

    assign btn_raw[BTN_START] = bus.btn_start_i;
    assign btn_raw[BTN_CLEAR] = bus.btn_clear_i;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign btn_raw[2] = bus.btn_lap_i;
`endif

    // Direction synchroniser resets to "up" so dir_o does not dip low right after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a <= '0;
            sync_b <= '0;
            deb    <= '0;
            deb_q  <= '0;
            db_cnt <= '0;
            dir_a  <= 1'b1;
            dir_b  <= 1'b1;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            deb_q  <= deb;
            dir_a  <= bus.dir_i;
            dir_b  <= dir_a;
            for (int i = 0; i < NB; i++) begin
                if (sync_b[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign press = deb & ~deb_q;

    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        tick_due  = (state == RUN) && (presc == PS_LAST);
        tick_en   = tick_due && !bus.count_end_i;
        if (press[BTN_CLEAR]) begin
            state_nxt = IDLE;
        end else if (tick_due && bus.count_end_i) begin
            state_nxt = DONE;
        end else if (press[BTN_START]) begin
            case (state)
                IDLE, PAUSE: state_nxt = RUN;
                RUN:         state_nxt = PAUSE;
                default:     state_nxt = state;
            endcase
        end
        // A pause taken on the tick cycle wraps, so resuming does not repeat that tick.
        case (state_nxt)
            RUN:     if (state == RUN) presc_nxt = tick_due ? '0 : presc + PS_W'(1);
            PAUSE:   if (tick_due) presc_nxt = '0;
            default: presc_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            presc        <= '0;
            clear_r      <= 1'b0;
            load_r       <= 1'b0;
            load_value_r <= '0;
            dir_r        <= 1'b1;
        end else begin
            state   <= state_nxt;
            presc   <= presc_nxt;
            clear_r <= press[BTN_CLEAR] && dir_r;
            load_r  <= press[BTN_CLEAR] && !dir_r;
            if (press[BTN_CLEAR] && !dir_r)
                load_value_r <= bus.load_value_i;
            if (state == IDLE)
                dir_r <= dir_b;
        end
    end

`ifdef STOPWATCH_CTRL_LAP_EN
    logic lap_freeze;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lap_freeze <= 1'b0;
        else if (state_nxt == IDLE)
            lap_freeze <= 1'b0;
        else if (press[2] && state == RUN)
            lap_freeze <= ~lap_freeze;
    end

    assign bus.lap_freeze_o = lap_freeze;
`endif

    assign bus.tick_en_o    = tick_en;
    assign bus.clear_o      = clear_r;
    assign bus.load_o       = load_r;
    assign bus.load_value_o = load_value_r;
    assign bus.dir_o        = dir_r;
    assign bus.state_o      = state;
endmodule
